// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} fq_state_e;

    // Counter width able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order FIFO with synchronous flush; the head is read straight from storage,
// so a push into an empty FIFO is visible the next cycle.
module sync_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4,
    parameter int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    input  logic             flush,
    output T                 head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential word fetch over req/gnt/rvalid,
// in-order instruction buffer toward decode, redirect with in-flight discard.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int CNT_W = cnt_w(DEPTH);

    fq_state_e        state, state_nxt;
    logic [XLEN-1:0]  fetch_pc, fetch_pc_nxt;
    logic [CNT_W-1:0] outstanding, outstanding_nxt;
    logic [CNT_W-1:0] discard, discard_nxt;

    fetch_entry_t     fifo_head, fifo_in;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;
    logic [XLEN-1:0]  pend_head;
    logic [CNT_W-1:0] pend_count;
    logic             pend_empty, pend_full;

    logic             fire, rsp, keep, pop, credit;
    logic [CNT_W:0]   inflight;
    logic             unused;

    // Entries already buffered plus requests still owed a response must fit in DEPTH.
    assign inflight = {1'b0, fifo_count} + {1'b0, outstanding};
    assign credit   = inflight < (CNT_W+1)'(DEPTH);

    assign imem_req_o  = (state == RUN) && !redirect_i && credit && !pend_full && !fifo_full;
    assign imem_addr_o = fetch_pc;
    assign fire        = imem_req_o && imem_gnt_i;
    assign rsp         = imem_rvalid_i && (outstanding != '0);
    assign keep        = rsp && !redirect_i && (discard == '0) && !pend_empty;

    assign instr_valid_o = !fifo_empty && !redirect_i;
    assign instr_o       = fifo_head.instr;
    assign instr_pc_o    = fifo_head.pc;
    assign pop           = instr_valid_o && instr_ready_i;

    assign fifo_in = '{pc: pend_head, instr: imem_rdata_i};
    assign unused  = ^{pend_count, redirect_pc_i[1:0]};

    always_comb begin
        fetch_pc_nxt    = fetch_pc;
        outstanding_nxt = outstanding + CNT_W'(fire) - CNT_W'(rsp);
        discard_nxt     = discard;
        state_nxt       = state;

        if (redirect_i) begin
            fetch_pc_nxt = {redirect_pc_i[XLEN-1:2], 2'b00};
            // Everything still in flight after this cycle belongs to the old path.
            discard_nxt  = outstanding - CNT_W'(rsp);
        end else begin
            if (fire) fetch_pc_nxt = fetch_pc + XLEN'(4);
            if (rsp && discard != '0) discard_nxt = discard - CNT_W'(1);
        end

        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (redirect_i && discard_nxt != '0) state_nxt = FLUSH;
            FLUSH:   if (!redirect_i && discard_nxt == '0) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
        end
    end

    sync_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_instr_q (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (keep),
        .push_data (fifo_in),
        .pop       (pop),
        .flush     (redirect_i),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // PCs of granted requests, matched in order against returning responses.
    sync_fifo #(.T(logic [XLEN-1:0]), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_pend_q (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (fire),
        .push_data (fetch_pc),
        .pop       (keep),
        .flush     (redirect_i),
        .head      (pend_head),
        .count     (pend_count),
        .empty     (pend_empty),
        .full      (pend_full)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory model answers one cycle after grant
// with rdata = addr + 0x1000_0000.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;
    logic        req, ivalid;
    logic [31:0] addr, instr, ipc;

    logic        req2, v2;
    logic [31:0] addr2, instr2, pc2;

    logic        nx_redirect = 1'b0, nx_gnt = 1'b0, nx_resp = 1'b0, nx_ready = 1'b0;
    logic [31:0] nx_rpc = '0;
    logic [31:0] mq[$];
    int          n_chk = 0, n_err = 0, grants;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
        .imem_rdata_i(rdata), .instr_valid_o(ivalid), .instr_o(instr), .instr_pc_o(ipc),
        .instr_ready_i(ready)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(1'b1), .imem_rvalid_i(1'b0),
        .imem_rdata_i(32'h0), .instr_valid_o(v2), .instr_o(instr2), .instr_pc_o(pc2),
        .instr_ready_i(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: apply next-cycle controls and any due response, then log a grant.
    task automatic step();
        @(posedge clk); #1;
        redirect    = nx_redirect;
        redirect_pc = nx_rpc;
        gnt         = nx_gnt;
        ready       = nx_ready;
        if (nx_resp && mq.size() > 0) begin
            rvalid = 1'b1;
            rdata  = mq[0] + 32'h1000_0000;
            void'(mq.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        #1;
        if (req && gnt) mq.push_back(addr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0;
        nx_redirect = 1'b0;
        mq.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_pc [4];
        logic [31:0] exp_a2 [4];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_a2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

        // reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_valid", {31'b0, ivalid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", ipc, 32'h0);
        chk("rst_addr2", addr2, 32'hFFFF_FFF8);

        // streaming, best-case latency, and address wrap on dut2
        nx_gnt = 1'b1; nx_resp = 1'b1; nx_ready = 1'b1;
        do_reset();
        step();
        chk("c1_req", {31'b0, req}, 32'h1);
        chk("c1_addr", addr, 32'h0);
        chk("c1_valid", {31'b0, ivalid}, 32'h0);
        chk("wrap_req0", {31'b0, req2}, 32'h1);
        chk("wrap_addr0", addr2, exp_a2[0]);
        step();
        chk("c2_valid", {31'b0, ivalid}, 32'h0);
        chk("wrap_addr1", addr2, exp_a2[1]);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", {31'b0, ivalid}, 32'h1);
            chk("stream_pc", ipc, exp_pc[i]);
            chk("stream_instr", instr, exp_pc[i] + 32'h1000_0000);
            if (i < 2) chk("wrap_addr", addr2, exp_a2[i+2]);
        end
        chk("wrap_stop", {31'b0, req2}, 32'h0);
        chk("wrap_novalid", {31'b0, v2}, 32'h0);
        chk("wrap_head", pc2 | instr2, 32'h0);

        // backpressure: exactly DEPTH grants, then one pop reopens one request
        nx_ready = 1'b0;
        do_reset();
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (req && gnt) grants++;
        end
        chk("bp_grants", grants, 32'd4);
        chk("bp_req_off", {31'b0, req}, 32'h0);
        nx_ready = 1'b1;
        step();
        chk("bp_pop_pc", ipc, 32'h0);
        chk("bp_pop_req", {31'b0, req}, 32'h0);
        nx_ready = 1'b0;
        step();
        chk("bp_resume_req", {31'b0, req}, 32'h1);
        chk("bp_resume_addr", addr, 32'h10);
        step();
        chk("bp_full_again", {31'b0, req}, 32'h0);

        // redirect with 3 outstanding: drop them, FLUSH, restart at 0x100
        nx_resp = 1'b0; nx_ready = 1'b1;
        do_reset();
        repeat (3) step();
        nx_redirect = 1'b1; nx_rpc = 32'h103;
        step();
        chk("rd_req", {31'b0, req}, 32'h0);
        chk("rd_valid", {31'b0, ivalid}, 32'h0);
        nx_redirect = 1'b0; nx_resp = 1'b1;
        step();
        chk("rd_state", 32'(dut.state), 32'(FLUSH));
        chk("rd_discard", 32'(dut.discard), 32'd3);
        chk("fl_req0", {31'b0, req}, 32'h0);
        repeat (2) begin
            step();
            chk("fl_req", {31'b0, req}, 32'h0);
            chk("fl_valid", {31'b0, ivalid}, 32'h0);
        end
        step();
        chk("rd_run", 32'(dut.state), 32'(RUN));
        chk("rd_new_addr", addr, 32'h100);
        chk("rd_new_req", {31'b0, req}, 32'h1);
        step();
        chk("rd_novalid", {31'b0, ivalid}, 32'h0);
        step();
        chk("rd_first_valid", {31'b0, ivalid}, 32'h1);
        chk("rd_first_pc", ipc, 32'h100);
        chk("rd_first_instr", instr, 32'h1000_0100);

        // redirect coinciding with rvalid, one outstanding, one buffered entry
        nx_resp = 1'b1; nx_ready = 1'b0;
        do_reset();
        step();
        step();
        nx_gnt = 1'b0; nx_redirect = 1'b1; nx_rpc = 32'h200; nx_ready = 1'b1;
        step();
        chk("rv_rd_valid", {31'b0, ivalid}, 32'h0);
        chk("rv_rd_req", {31'b0, req}, 32'h0);
        chk("rv_rd_rvalid", {31'b0, rvalid}, 32'h1);
        nx_redirect = 1'b0; nx_gnt = 1'b1;
        step();
        chk("rv_state", 32'(dut.state), 32'(RUN));
        chk("rv_discard", 32'(dut.discard), 32'd0);
        chk("rv_req", {31'b0, req}, 32'h1);
        chk("rv_addr", addr, 32'h200);
        chk("rv_empty", {31'b0, ivalid}, 32'h0);
        step();
        step();
        chk("rv_pc", ipc, 32'h200);
        chk("rv_instr", instr, 32'h1000_0200);

        // asynchronous reset while the FIFO is full
        nx_ready = 1'b0;
        do_reset();
        repeat (8) step();
        chk("full_valid", {31'b0, ivalid}, 32'h1);
        chk("full_pc", ipc, 32'h0);
        chk("full_req", {31'b0, req}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, req}, 32'h0);
        chk("arst_valid", {31'b0, ivalid}, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_pc", ipc, 32'h0);
        chk("arst_addr", addr, 32'h0);
        do_reset();
        step();
        chk("arst_first_req", {31'b0, req}, 32'h1);
        chk("arst_first_addr", addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits between the PC/instruction-memory port and the decode stage.
- Generates sequential word fetch addresses and issues them over a req/gnt/rvalid handshake to main memory.
- Buffers returned instructions with their PC in an in-order FIFO and presents them to decode under a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- DEPTH, 4, number of FIFO entries; also the cap on entries plus outstanding requests; power of two, >= 2.
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- redirect_i  input  1  flush the queue and restart fetch at redirect_pc_i.
- redirect_pc_i  input  XLEN  new fetch address; bits [1:0] are ignored and treated as 0.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  XLEN  fetch word address; word aligned.
- imem_gnt_i  input  1  request accepted in the cycle imem_req_o && imem_gnt_i.
- imem_rvalid_i  input  1  response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata_i  input  XLEN  instruction word.
- instr_valid_o  output  1  head entry valid toward decode.
- instr_o  output  XLEN  head instruction.
- instr_pc_o  output  XLEN  PC of the head instruction.
- instr_ready_i  input  1  decode consumes the head when instr_valid_o && instr_ready_i.

Behaviour:
- Clock and reset: single clock clk_i. rst_n_i is asynchronous and active-low; assertion clears all state immediately, independent of the clock.
- Reset values:
  - state = IDLE, fetch_pc = RESET_PC, FIFO empty, outstanding = 0, discard = 0.
  - imem_req_o = 0, imem_addr_o = RESET_PC.
  - instr_valid_o = 0, instr_o = 0, instr_pc_o = 0.
- FSM states:
  - IDLE: one cycle after reset release, then RUN.
  - RUN: normal fetch.
  - FLUSH: discarding in-flight responses after a redirect.
- FSM transitions:
  - IDLE -> RUN unconditionally.
  - RUN -> FLUSH on redirect_i when in-flight responses remain after the current cycle; otherwise RUN -> RUN with the new PC.
  - FLUSH -> RUN when discard reaches 0.
  - redirect_i in FLUSH reloads the PC and discard count and stays in FLUSH.
- Request issue:
  - imem_req_o = 1 only when state == RUN, redirect_i == 0, and (fifo_count + outstanding) < DEPTH.
  - imem_addr_o = fetch_pc.
  - On grant: fetch_pc += 4 with modulo-2^XLEN wrap (32'hFFFF_FFFC -> 0), and outstanding increments.
  - Each request records its PC in a pending-PC queue of DEPTH entries.
- Response path:
  - When discard == 0, each rvalid pushes {pending_pc, imem_rdata_i} into the FIFO and decrements outstanding.
  - When discard > 0, the response is dropped and both discard and outstanding decrement.
  - The credit rule guarantees a push never hits a full FIFO.
  - Grant and rvalid in the same cycle leave outstanding unchanged.
- Output:
  - instr_valid_o = !fifo_empty && !redirect_i; instr_o and instr_pc_o come from the FIFO head.
  - Push and pop in the same cycle keep the count unchanged, at any occupancy.
  - Data written into an empty FIFO appears on the output the cycle after the rvalid (1-cycle registered latency).
  - Best-case latency: reset release -> req at cycle 1 -> gnt cycle 1 -> rvalid cycle 2 -> instr_valid_o cycle 3.
- Redirect (takes priority over every other event in the same cycle):
  - FIFO cleared; a pop in that cycle is not counted as a consume.
  - No request is issued that cycle.
  - fetch_pc = {redirect_pc_i[XLEN-1:2], 2'b00}.
  - discard = outstanding minus 1 if rvalid is in this cycle; that rvalid is itself dropped.
  - Pending-PC queue cleared.
- Backpressure: with instr_ready_i held low, fetching stops once fifo_count + outstanding == DEPTH and resumes the cycle after a pop.
- Reset asserted mid-transaction: all state clears immediately. Responses that arrive after reset release are undefined; the memory is reset on the same reset.

Decomposition:
- Package fetch_pkg:
  - XLEN constant.
  - fetch_entry_t struct {pc, instr}.
  - fq_state_e enum {IDLE, RUN, FLUSH}.
  - Width helper CNT_W = $clog2(DEPTH+1).
- Sub-module sync_fifo: parameterised on the entry type and DEPTH, with push, pop, flush, count, empty and full. It is instantiated twice, once for the instruction queue and once for the pending-PC queue.

Test Plan:
- Reset, then gnt tied 1 and rvalid 1 cycle after each grant, ready = 1 -> instr_pc_o sequence 0x0, 0x4, 0x8, 0xC, with valid first seen at cycle 3.
- ready = 0, DEPTH = 4 -> exactly 4 grants, then imem_req_o stays 0. Set ready = 1 for one cycle -> one pop and one new request the next cycle.
- 3 requests outstanding, redirect_i with pc 0x103 -> those 3 responses are dropped and state is FLUSH. The next request address is 0x100, and the first instr_pc_o is 0x100.
- Redirect in the same cycle as rvalid, with handshake and 1 outstanding -> nothing pushed, no consume counted, discard = 0, and fetch resumes at the redirect PC next cycle.
- RESET_PC = 32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rst_n_i low between clock edges while the FIFO is full -> all outputs are 0 immediately. After release, the first request goes to RESET_PC.
